// File: rtl/cpu_mc_pkg.sv
// Shared types and constants for the cpu_mc multi-cycle core: FSM states,
// opcodes, ALU control encodings, immediate formats and small helpers.
package cpu_mc_pkg;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Same encodings as the single-cycle controller so both cores share ALU test vectors.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_sel_t;

    function automatic logic [31:0] build_imm(input logic [31:0] ir, input imm_sel_t sel);
        logic [31:0] imm;
        case (sel)
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = {{20{ir[31]}}, ir[31:20]};
        endcase
        return imm;
    endfunction

    function automatic logic [31:0] alu_op(input logic [3:0] ctl, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] y;
        case (ctl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
            default: y = a + b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// Architectural register file: two combinational read ports, one write port
// on the clock edge, x0 reads as zero and ignores writes, async clear.
module cpu_mc_regfile #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    localparam int AW = $clog2(NREGS);

    logic [31:0] regs [NREGS];

    // Register storage; index 0 is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (wa[AW-1:0] != '0)) begin
            regs[wa[AW-1:0]] <= wd;
        end
    end

    // Read ports; x0 forced to zero independent of storage.
    always_comb begin
        rd1 = (ra1[AW-1:0] == '0) ? 32'd0 : regs[ra1[AW-1:0]];
        rd2 = (ra2[AW-1:0] == '0) ? 32'd0 : regs[ra2[AW-1:0]];
    end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle RV32I-subset core with one unified req/ready memory port.
// Traps (illegal encoding, misaligned data address or jump target) park the
// core in S_HALT until reset.
// Optional build macro CPU_MC_PERF_EN adds cycle_cnt / instret_cnt outputs.
//
// state    | meaning
// S_BOOT   | one idle cycle after reset release
// S_FETCH  | read instruction at pc, wait for mem_ready
// S_DECODE | read rs1/rs2, build immediate, compute pc+4, reject illegal
// S_EXEC   | ALU op, EA, branch/jump resolve, alignment traps
// S_MEM    | data transfer at EA, wait for mem_ready
// S_WB     | write rd, advance pc
// S_HALT   | trapped; bus idle, pc frozen
module cpu_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32,
    parameter int          XLEN     = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        halted
`ifdef CPU_MC_PERF_EN
    ,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
`endif
);
    import cpu_mc_pkg::*;

    if (XLEN != 32) begin : g_xlen_chk
        $error("cpu_mc: XLEN must be 32");
    end
    if ((NREGS != 32) && (NREGS != 16)) begin : g_nregs_chk
        $error("cpu_mc: NREGS must be 32 or 16");
    end

    state_t      state_q, state_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, pc4_q, res_q;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        legal, idx_ok, is_r, is_lw, is_sw, is_beq, is_jal;
    logic        use_rs1, use_rs2, use_rd;
    logic [3:0]  alu_ctl;
    imm_sel_t    imm_sel;
    logic [31:0] rf_rd1, rf_rd2, alu_y, ea, target;
    logic        take;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    // Instruction decode from the latched IR.
    always_comb begin
        legal   = 1'b0;
        is_r    = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        is_jal  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        alu_ctl = ALU_ADD;
        imm_sel = IMM_I;
        case (opcode)
            OP_R: begin
                is_r    = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  begin legal = 1'b1; alu_ctl = ALU_ADD; end
                        3'b111:  begin legal = 1'b1; alu_ctl = ALU_AND; end
                        3'b110:  begin legal = 1'b1; alu_ctl = ALU_OR;  end
                        3'b010:  begin legal = 1'b1; alu_ctl = ALU_SLT; end
                        default: legal = 1'b0;
                    endcase
                end else if ((funct7 == 7'b0100000) && (funct3 == 3'b000)) begin
                    legal   = 1'b1;
                    alu_ctl = ALU_SUB;
                end
            end
            OP_I: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                case (funct3)
                    3'b000:  begin legal = 1'b1; alu_ctl = ALU_ADD; end
                    3'b111:  begin legal = 1'b1; alu_ctl = ALU_AND; end
                    3'b110:  begin legal = 1'b1; alu_ctl = ALU_OR;  end
                    3'b010:  begin legal = 1'b1; alu_ctl = ALU_SLT; end
                    default: legal = 1'b0;
                endcase
            end
            OP_LW: begin
                is_lw   = 1'b1;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                legal   = (funct3 == 3'b010);
            end
            OP_SW: begin
                is_sw   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_sel = IMM_S;
                legal   = (funct3 == 3'b010);
            end
            OP_BEQ: begin
                is_beq  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_sel = IMM_B;
                alu_ctl = ALU_SUB;
                legal   = (funct3 == 3'b000);
            end
            OP_JAL: begin
                is_jal  = 1'b1;
                use_rd  = 1'b1;
                imm_sel = IMM_J;
                legal   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // RV32E: any register field the instruction actually uses must stay below x16.
    always_comb begin
        idx_ok = 1'b1;
        if (NREGS == 16)
            idx_ok = !((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]));
    end

    assign alu_y  = alu_op(alu_ctl, a_q, is_r ? b_q : imm_q);
    assign ea     = a_q + imm_q;
    assign target = pc_q + imm_q;
    assign take   = (a_q == b_q);

    cpu_mc_regfile #(.NREGS(NREGS)) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .ra1     (rs1),
        .ra2     (rs2),
        .we      (state_q == S_WB),
        .wa      (rd),
        .wd      (res_q),
        .rd1     (rf_rd1),
        .rd2     (rf_rd2)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_BOOT;
        else          state_q <= state_d;
    end

    // Next state and bus outputs; bus fields come straight from held registers so they stay stable during waits.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: state_d = (legal && idx_ok) ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (is_lw || is_sw)
                    state_d = (ea[1:0] != 2'b00) ? S_HALT : S_MEM;
                else if (is_beq)
                    state_d = (take && (target[1:0] != 2'b00)) ? S_HALT : S_FETCH;
                else if (is_jal)
                    state_d = (target[1:0] != 2'b00) ? S_HALT : S_WB;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_sw;
                mem_addr  = res_q;
                mem_wdata = b_q;
                if (mem_ready) state_d = is_sw ? S_FETCH : S_WB;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Datapath registers; res_q carries EA, ALU result, link address or load data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
            pc4_q <= '0;
            res_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: if (mem_ready) ir_q <= mem_rdata;
                S_DECODE: begin
                    a_q   <= rf_rd1;
                    b_q   <= rf_rd2;
                    imm_q <= build_imm(ir_q, imm_sel);
                    pc4_q <= pc_q + 32'd4;
                end
                S_EXEC: begin
                    if (is_jal) begin
                        res_q <= pc4_q;
                        if (target[1:0] == 2'b00) pc_q <= target;
                    end else if (is_beq) begin
                        if (!take)                        pc_q <= pc4_q;
                        else if (target[1:0] == 2'b00)    pc_q <= target;
                    end else begin
                        res_q <= (is_lw || is_sw) ? ea : alu_y;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_sw) pc_q  <= pc4_q;
                        else       res_q <= mem_rdata;
                    end
                end
                S_WB: if (!is_jal) pc_q <= pc4_q;
                default: ;
            endcase
        end
    end

    assign pc     = pc_q;
    assign halted = (state_q == S_HALT);

`ifdef CPU_MC_PERF_EN
    logic retire;
    assign retire = (state_q == S_WB) ||
                    ((state_q == S_MEM) && is_sw && mem_ready) ||
                    ((state_q == S_EXEC) && is_beq && (state_d == S_FETCH));

    // Performance counters: active cycles and retired instructions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if ((state_q != S_BOOT) && (state_q != S_HALT)) cycle_cnt <= cycle_cnt + 64'd1;
            if (retire) instret_cnt <= instret_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_mc.sv
// Directed testbench for cpu_mc with a behavioural wait-state memory.
module tb_cpu_mc;

    localparam logic [6:0] T_OP_R = 7'b0110011, T_OP_I = 7'b0010011, T_OP_LW = 7'b0000011;
    localparam logic [31:0] ILLEGAL = 32'h0000_007F;

    logic        clk;
    logic        reset_n;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] mem [1024];
    logic [31:0] log_addr [$];
    int wait_cycles = 0;
    int wcnt        = 0;
    int stab_err    = 0;
    int wait_seen   = 0;
    logic        hold_v = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;

    cpu_mc #(.RESET_PC(32'h0), .NREGS(32), .XLEN(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ready = mem_req && (wcnt >= wait_cycles);
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    // Memory side: stability check, wait accounting, write commit and transfer log.
    always @(negedge clk) begin
        if (hold_v && reset_n) begin
            if (!mem_req || mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata)
                stab_err++;
        end
        hold_v  = reset_n && mem_req && !mem_ready;
        h_addr  = mem_addr;
        h_we    = mem_we;
        h_wdata = mem_wdata;
        if (reset_n && mem_req) begin
            if (!mem_ready) wait_seen++;
            else begin
                log_addr.push_back(mem_addr);
                if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, T_OP_R};
    endfunction
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_sw(input logic [31:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_beq(input logic [31:0] imm, input logic [4:0] rs2,
                                            input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_jal(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    endtask

    task automatic start_run();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        log_addr.delete();
        stab_err  = 0;
        wait_seen = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_to_halt(input int limit, output int edges);
        int n = 0;
        while (!halted && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        edges = halted ? n : -1;
    endtask

    task automatic test_reset();
        int e;
        clear_mem();
        #1;
        vectors++;
        if ({mem_req, mem_we, halted} !== 3'b000 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: req/we/halted=%b addr=%h wdata=%h, required 000/0/0",
                     {mem_req, mem_we, halted}, mem_addr, mem_wdata);
        end
        vectors++;
        if (pc !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_pc: got %h, required 00000000", pc);
        end
        @(posedge clk); #1;
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold_req: got %b, required 0", mem_req);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_no_req: got %b, required 0", mem_req);
        end
        @(posedge clk); #1;
        vectors++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL first_fetch: req=%b we=%b addr=%h, required 1/0/00000000",
                     mem_req, mem_we, mem_addr);
        end
        run_to_halt(20, e);
        vectors++;
        if (e !== 2) begin
            miscompares++;
            $display("FAIL zero_word_halt: edges=%0d, required 2", e);
        end
    endtask

    task automatic test_alu();
        int e;
        logic [31:0] da [10];
        logic [31:0] dv [10];
        da = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h310, 32'h314, 32'h318, 32'h31C, 32'h320, 32'h324};
        dv = '{32'd12, 32'hFFFF_FFFE, 32'd5, 32'd7, 32'd1, 32'd0, 32'h0F0, 32'h105, 32'd0, 32'd0};
        clear_mem();
        for (int i = 0; i < 10; i++) mem[da[i] >> 2] = 32'hAAAA_AAAA;
        mem[0]  = enc_i(32'd5, 5'd0, 3'b000, 5'd1, T_OP_I);
        mem[1]  = enc_i(32'd7, 5'd0, 3'b000, 5'd2, T_OP_I);
        mem[2]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
        mem[3]  = enc_sw(32'h300, 5'd3, 5'd0);
        mem[4]  = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4);
        mem[5]  = enc_sw(32'h304, 5'd4, 5'd0);
        mem[6]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd5);
        mem[7]  = enc_sw(32'h308, 5'd5, 5'd0);
        mem[8]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd6);
        mem[9]  = enc_sw(32'h30C, 5'd6, 5'd0);
        mem[10] = enc_r(7'b0000000, 5'd1, 5'd4, 3'b010, 5'd7);
        mem[11] = enc_sw(32'h310, 5'd7, 5'd0);
        mem[12] = enc_i(32'hFFFF_FFFF, 5'd1, 3'b010, 5'd8, T_OP_I);
        mem[13] = enc_sw(32'h314, 5'd8, 5'd0);
        mem[14] = enc_i(32'h0F0, 5'd4, 3'b111, 5'd9, T_OP_I);
        mem[15] = enc_sw(32'h318, 5'd9, 5'd0);
        mem[16] = enc_i(32'h100, 5'd1, 3'b110, 5'd10, T_OP_I);
        mem[17] = enc_sw(32'h31C, 5'd10, 5'd0);
        mem[18] = enc_i(32'hFFFF_FFFF, 5'd0, 3'b000, 5'd11, T_OP_I);
        mem[19] = enc_i(32'd1, 5'd11, 3'b000, 5'd12, T_OP_I);
        mem[20] = enc_sw(32'h320, 5'd12, 5'd0);
        mem[21] = enc_r(7'b0000000, 5'd4, 5'd1, 3'b010, 5'd13);
        mem[22] = enc_sw(32'h324, 5'd13, 5'd0);
        mem[23] = ILLEGAL;
        wait_cycles = 0;
        start_run();
        repeat (12) @(posedge clk);
        #1;
        vectors++;
        if (pc !== 32'h8 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL add_in_wb: pc=%h req=%b, required 00000008/0", pc, mem_req);
        end
        @(posedge clk); #1;
        vectors++;
        if (pc !== 32'hC || mem_req !== 1'b1 || mem_addr !== 32'hC) begin
            miscompares++;
            $display("FAIL retire_12: pc=%h req=%b addr=%h, required 0000000c/1/0000000c",
                     pc, mem_req, mem_addr);
        end
        run_to_halt(500, e);
        vectors++;
        if (e < 0) begin
            miscompares++;
            $display("FAIL alu_prog_halt: timed out, required halt");
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (mem[da[i] >> 2] !== dv[i]) begin
                miscompares++;
                $display("FAIL alu_result[%0d] @%h: got %h, required %h", i, da[i], mem[da[i] >> 2], dv[i]);
            end
        end
    endtask

    task automatic test_mem_wait();
        int e;
        clear_mem();
        mem[0] = enc_i(32'd12, 5'd0, 3'b000, 5'd3, T_OP_I);
        mem[1] = enc_sw(32'h40, 5'd3, 5'd0);
        mem[2] = enc_i(32'h40, 5'd0, 3'b010, 5'd4, T_OP_LW);
        mem[3] = enc_sw(32'h44, 5'd4, 5'd0);
        mem[4] = ILLEGAL;
        mem[17] = 32'h5555_5555;
        wait_cycles = 3;
        start_run();
        run_to_halt(200, e);
        vectors++;
        if (e !== 44) begin
            miscompares++;
            $display("FAIL wait_latency: halted after %0d edges, required 44", e);
        end
        vectors++;
        if (mem[16] !== 32'd12 || mem[17] !== 32'd12) begin
            miscompares++;
            $display("FAIL sw_lw_data: m40=%h m44=%h, required 0000000c/0000000c", mem[16], mem[17]);
        end
        vectors++;
        if (stab_err !== 0) begin
            miscompares++;
            $display("FAIL req_stability: %0d unstable wait cycles, required 0", stab_err);
        end
        vectors++;
        if (wait_seen !== 24) begin
            miscompares++;
            $display("FAIL wait_count: %0d wait cycles, required 24", wait_seen);
        end
        wait_cycles = 0;
    endtask

    task automatic test_branch();
        int e;
        logic [31:0] off [3];
        logic [4:0]  r2  [3];
        int          eh  [3];
        logic [31:0] la  [3];
        off = '{32'd8, 32'd8, 32'd6};
        r2  = '{5'd1, 5'd2, 5'd1};
        eh  = '{22, 22, 20};
        la  = '{32'h18, 32'h14, 32'h10};
        for (int k = 0; k < 3; k++) begin
            clear_mem();
            mem[0] = enc_i(32'd3, 5'd0, 3'b000, 5'd1, T_OP_I);
            mem[1] = enc_i(32'd4, 5'd0, 3'b000, 5'd2, T_OP_I);
            mem[2] = enc_i(32'd0, 5'd0, 3'b000, 5'd0, T_OP_I);
            mem[3] = enc_i(32'd0, 5'd0, 3'b000, 5'd0, T_OP_I);
            mem[4] = enc_beq(off[k], r2[k], 5'd1);
            mem[5] = ILLEGAL;
            mem[6] = ILLEGAL;
            start_run();
            run_to_halt(100, e);
            vectors++;
            if (e !== eh[k]) begin
                miscompares++;
                $display("FAIL beq_case%0d_latency: halted after %0d edges, required %0d", k, e, eh[k]);
            end
            vectors++;
            if (log_addr.size() == 0 || log_addr[log_addr.size() - 1] !== la[k]) begin
                miscompares++;
                $display("FAIL beq_case%0d_last_fetch: got %h, required %h", k,
                         (log_addr.size() == 0) ? 32'hXXXX_XXXX : log_addr[log_addr.size() - 1], la[k]);
            end
        end
        vectors++;
        if (pc !== 32'h10) begin
            miscompares++;
            $display("FAIL beq_misaligned_pc: got %h, required 00000010", pc);
        end
    endtask

    task automatic test_jal();
        int e;
        clear_mem();
        mem[0]   = enc_jal(32'h20, 5'd0);
        mem[8]   = enc_jal(32'h100, 5'd1);
        mem[72]  = enc_sw(32'h80, 5'd1, 5'd0);
        mem[73]  = enc_jal(32'd8, 5'd0);
        mem[74]  = ILLEGAL;
        mem[75]  = enc_sw(32'h84, 5'd0, 5'd0);
        mem[76]  = ILLEGAL;
        mem[32]  = 32'hDEAD_BEEF;
        mem[33]  = 32'hDEAD_BEEF;
        start_run();
        run_to_halt(100, e);
        vectors++;
        if (e !== 23) begin
            miscompares++;
            $display("FAIL jal_latency: halted after %0d edges, required 23", e);
        end
        vectors++;
        if (log_addr.size() < 3 || log_addr[1] !== 32'h20 || log_addr[2] !== 32'h120) begin
            miscompares++;
            $display("FAIL jal_fetch_order: %0d transfers, second/third addr not 00000020/00000120",
                     log_addr.size());
        end
        vectors++;
        if (mem[32] !== 32'h24) begin
            miscompares++;
            $display("FAIL jal_link: x1=%h, required 00000024", mem[32]);
        end
        vectors++;
        if (mem[33] !== 32'd0) begin
            miscompares++;
            $display("FAIL jal_x0: x0=%h, required 00000000", mem[33]);
        end
        vectors++;
        if (pc !== 32'h130) begin
            miscompares++;
            $display("FAIL jal_final_pc: got %h, required 00000130", pc);
        end
    endtask

    task automatic test_trap();
        int e;
        int req_cnt;
        logic [31:0] w  [3];
        int          eh [3];
        w  = '{ILLEGAL, enc_i(32'h41, 5'd0, 3'b010, 5'd2, T_OP_LW),
               enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3)};
        eh = '{3, 4, 3};
        for (int k = 0; k < 3; k++) begin
            clear_mem();
            mem[0] = w[k];
            start_run();
            run_to_halt(50, e);
            vectors++;
            if (e !== eh[k]) begin
                miscompares++;
                $display("FAIL trap%0d_edge: halted after %0d edges, required %0d", k, e, eh[k]);
            end
            req_cnt = 0;
            repeat (5) begin
                @(posedge clk); #1;
                if (mem_req !== 1'b0 || halted !== 1'b1) req_cnt++;
            end
            vectors++;
            if (req_cnt !== 0 || pc !== 32'd0 || log_addr.size() !== 1) begin
                miscompares++;
                $display("FAIL trap%0d_frozen: bad cycles=%0d pc=%h transfers=%0d, required 0/00000000/1",
                         k, req_cnt, pc, log_addr.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        int e;
        bit found = 1'b0;
        clear_mem();
        mem[0] = enc_i(32'h55, 5'd0, 3'b000, 5'd6, T_OP_I);
        mem[1] = enc_i(32'h40, 5'd0, 3'b010, 5'd7, T_OP_LW);
        wait_cycles = 5;
        start_run();
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 32'h40) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mid_reset_reach_mem: lw transfer not observed within 100 cycles");
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || mem_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset_drop: req=%b addr=%h, required 0/00000000", mem_req, mem_addr);
        end
        clear_mem();
        mem[0]  = enc_sw(32'h44, 5'd6, 5'd0);
        mem[1]  = ILLEGAL;
        mem[17] = 32'hFFFF_FFFF;
        wait_cycles = 0;
        start_run();
        #1;
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_boot: req=%b, required 0", mem_req);
        end
        @(posedge clk); #1;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset_refetch: req=%b addr=%h, required 1/00000000", mem_req, mem_addr);
        end
        run_to_halt(50, e);
        vectors++;
        if (e < 0 || mem[17] !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset_regs: edges=%0d x6=%h, required halt and 00000000", e, mem[17]);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        test_reset();
        test_alu();
        test_mem_wait();
        test_branch();
        test_jal();
        test_trap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
